// File: rtl/packet_demodulator_if.sv
// Sample-in / byte-out bus of packet_demodulator.
// The master modport is the sample source and byte sink side.
interface packet_demodulator_if #(
  parameter int SIZE_INPUT_BIT  = 32,
  parameter int SIZE_OUTPUT_BIT = 8
);
  logic [SIZE_INPUT_BIT-1:0]  i_data;
  logic                       i_valid_input;
  logic [SIZE_OUTPUT_BIT-1:0] o_data;
  logic                       o_valid_output;
  logic                       i_ready;
  logic                       o_sync;
  logic                       o_pack_done;
  logic                       o_overflow;

  modport master (
    output i_data, i_valid_input, i_ready,
    input  o_data, o_valid_output, o_sync, o_pack_done, o_overflow
  );
  modport slave (
    input  i_data, i_valid_input, i_ready,
    output o_data, o_valid_output, o_sync, o_pack_done, o_overflow
  );
endinterface

// File: rtl/packet_demodulator.sv
// DSSS packet demodulator: despreads I, hunts the preamble, emits payload bytes via a show-ahead FIFO.
// Build option: define DEMOD_PREAMBLE_TOL_EN to accept a preamble within MAX_ERR bit errors.
module packet_demodulator #(
  parameter int                       SIZE_OUTPUT_BIT = 8,
  parameter int                       SIZE_INPUT_BIT  = 32,
  parameter int                       SIZE_QI         = 16,
  parameter int                       SIZE_BIT_PACK   = 1976,
  parameter int                       SISE_PREAMBLE   = 32,
  parameter logic [SISE_PREAMBLE-1:0] PREAMBLE        = 32'hEB90_EB90,
  parameter int                       CHIPS_PER_BIT   = 30,
  parameter logic [CHIPS_PER_BIT-1:0] CODE            = 30'h1E5C_9E21,
  parameter int                       MAX_ERR         = 2,
  parameter int                       FIFO_DEPTH      = 4
) (
  input logic                 i_clk,
  input logic                 i_reset,
  packet_demodulator_if.slave bus
);
  localparam int ACC_W      = SIZE_QI + $clog2(CHIPS_PER_BIT) + 1;
  localparam int CHIP_W     = $clog2(CHIPS_PER_BIT);
  localparam int PAY_BITS   = SIZE_BIT_PACK - SISE_PREAMBLE;
  localparam int BCNT_W     = $clog2(PAY_BITS);
  localparam int BYTE_IDX_W = $clog2(SIZE_OUTPUT_BIT);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  typedef enum logic {HUNT, PAYLOAD} state_t;

  logic signed [SIZE_QI-1:0] w_i;
  logic signed [ACC_W-1:0]   w_i_ext, w_contrib, w_sum, r_acc;
  logic [CHIP_W-1:0]         r_chip_cnt, w_code_idx;
  logic                      w_last_chip, r_bit, r_bit_valid;
  logic                      w_unused_q;

  assign w_i         = bus.i_data[SIZE_QI-1:0];
  assign w_unused_q  = ^bus.i_data[SIZE_INPUT_BIT-1:SIZE_QI];
  assign w_i_ext     = ACC_W'(w_i);
  assign w_code_idx  = CHIP_W'(CHIPS_PER_BIT - 1) - r_chip_cnt;
  assign w_contrib   = CODE[w_code_idx] ? w_i_ext : -w_i_ext;
  assign w_sum       = r_acc + w_contrib;
  assign w_last_chip = (r_chip_cnt == CHIP_W'(CHIPS_PER_BIT - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_acc       <= '0;
      r_chip_cnt  <= '0;
      r_bit       <= 1'b0;
      r_bit_valid <= 1'b0;
    end else begin
      r_bit_valid <= 1'b0;
      if (bus.i_valid_input) begin
        if (w_last_chip) begin
          r_acc       <= '0;
          r_chip_cnt  <= '0;
          r_bit       <= ~w_sum[ACC_W-1];   // zero correlation decides 1
          r_bit_valid <= 1'b1;
        end else begin
          r_acc      <= w_sum;
          r_chip_cnt <= r_chip_cnt + 1'b1;
        end
      end
    end
  end

  state_t                     r_state, w_state_next;
  logic [SISE_PREAMBLE-1:0]   r_sr, w_sr_next, w_sr_shift;
  logic [BCNT_W-1:0]          r_bit_cnt, w_bit_cnt_next;
  logic [SIZE_OUTPUT_BIT-1:0] r_byte, w_byte_next;
  logic                       r_push, w_push_next, r_pack_done, w_pack_done_next;
  logic                       w_match;

  assign w_sr_shift = {r_sr[SISE_PREAMBLE-2:0], r_bit};

`ifdef DEMOD_PREAMBLE_TOL_EN
  localparam int DIST_W = $clog2(SISE_PREAMBLE + 1);
  logic [DIST_W-1:0] w_dist;
  always_comb begin
    w_dist = '0;
    for (int k = 0; k < SISE_PREAMBLE; k++)
      w_dist = w_dist + DIST_W'(w_sr_shift[k] ^ PREAMBLE[k]);
  end
  assign w_match = (w_dist <= DIST_W'(MAX_ERR));
`else
  logic w_unused_max_err;
  assign w_unused_max_err = (MAX_ERR != 0);  // tolerance has no effect with exact matching
  assign w_match          = (w_sr_shift == PREAMBLE);
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= HUNT;
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_byte      <= '0;
      r_push      <= 1'b0;
      r_pack_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_sr        <= w_sr_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_byte      <= w_byte_next;
      r_push      <= w_push_next;
      r_pack_done <= w_pack_done_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_sr_next        = r_sr;
    w_bit_cnt_next   = r_bit_cnt;
    w_byte_next      = r_byte;
    w_push_next      = 1'b0;
    w_pack_done_next = 1'b0;
    case (r_state)
      HUNT: begin
        if (r_bit_valid) begin
          w_sr_next = w_sr_shift;
          if (w_match) begin
            w_state_next   = PAYLOAD;
            w_bit_cnt_next = '0;
          end
        end
      end
      PAYLOAD: begin
        if (r_bit_valid) begin
          w_byte_next    = {r_byte[SIZE_OUTPUT_BIT-2:0], r_bit};
          w_bit_cnt_next = r_bit_cnt + 1'b1;
          w_push_next    = (r_bit_cnt[BYTE_IDX_W-1:0] == '1);
          if (r_bit_cnt == BCNT_W'(PAY_BITS - 1)) begin
            w_pack_done_next = 1'b1;
            w_state_next     = HUNT;
            w_sr_next        = '0;
            w_bit_cnt_next   = '0;
          end
        end
      end
      default: w_state_next = HUNT;
    endcase
  end

  // Output FIFO: pointers carry one wrap bit to tell full from empty.
  logic [SIZE_OUTPUT_BIT-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W:0]             r_wr_ptr, r_rd_ptr;
  logic                       r_overflow, w_empty, w_full, w_pop, w_wr_en;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_pop   = !w_empty && bus.i_ready;
  assign w_wr_en = r_push && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_wr_en)
      r_mem[r_wr_ptr[PTR_W-1:0]] <= r_byte;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (r_push && w_full && !w_pop)
        r_overflow <= 1'b1;
    end
  end

  assign bus.o_data         = w_empty ? '0 : r_mem[r_rd_ptr[PTR_W-1:0]];
  assign bus.o_valid_output = !w_empty;
  assign bus.o_sync         = (r_state == PAYLOAD);
  assign bus.o_pack_done    = r_pack_done;
  assign bus.o_overflow     = r_overflow;
endmodule

// File: tb/tb_packet_demodulator.sv
// Directed/randomized bench for packet_demodulator with a bit-level reference model.
// Packets are shortened to 10 payload bytes to keep runs brief.
module tb_packet_demodulator;
  localparam int          CPB       = 30;
  localparam logic [29:0] CODE      = 30'h1E5C_9E21;
  localparam logic [31:0] PRE       = 32'hEB90_EB90;
  localparam int          PAY_BYTES = 10;
  localparam int          PAY_BITS  = PAY_BYTES * 8;
`ifdef DEMOD_PREAMBLE_TOL_EN
  localparam int TOL = 2;
`else
  localparam int TOL = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0, miscompares = 0;
  int sync_cycles = 0, done_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [29:0] code_v = CODE;
  logic [31:0] m_sr = '0;
  bit          m_sync = 1'b0;
  int          m_cnt = 0, m_packs = 0;
  logic [7:0]  m_byte = '0;

  always #5 clk = ~clk;

  packet_demodulator_if bus ();
  packet_demodulator #(.SIZE_BIT_PACK(32 + PAY_BITS)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_valid_output && bus.i_ready) rx_q.push_back(bus.o_data);
      if (bus.o_sync) sync_cycles++;
      if (bus.o_pack_done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input bit v, input int ival);
    @(posedge clk); #1;
    bus.i_valid_input = v;
    bus.i_data        = {16'($urandom), 16'(ival)};
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, int'($urandom_range(65535)) - 32768);
  endtask

  // Reference: packet rules applied to decided bits.
  task automatic model_bit(input bit d);
    if (!m_sync) begin
      m_sr = {m_sr[30:0], d};
      if ($countones(m_sr ^ PRE) <= TOL) begin
        m_sync = 1'b1;
        m_cnt  = 0;
      end
    end else begin
      m_byte = {m_byte[6:0], d};
      m_cnt++;
      if (m_cnt % 8 == 0) exp_q.push_back(m_byte);
      if (m_cnt == PAY_BITS) begin
        m_sync = 1'b0;
        m_sr   = '0;
        m_packs++;
      end
    end
  endtask

  task automatic send_bit(input bit b, input int noise, input bit gaps, input bit zero);
    int corr, cs, iv;
    corr = 0;
    for (int c = 0; c < CPB; c++) begin
      cs = code_v[CPB-1-c] ? 1 : -1;
      iv = zero ? 0 : (b ? 1000 : -1000) * cs;
      if (noise > 0 && !zero) iv += int'($urandom_range(2 * noise)) - noise;
      if (gaps && $urandom_range(3) == 0) idle(1);
      drive(1'b1, iv);
      corr += cs * iv;
    end
    model_bit(corr >= 0);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) send_bit(v[k], 0, 1'b0, 1'b0);
  endtask

  task automatic send_payload(input int noise, input bit gaps, input int first, input int last,
                              input int zero_bit);
    logic [7:0] bv;
    for (int j = first; j <= last; j++) begin
      bv = 8'(j);
      for (int k = 7; k >= 0; k--) send_bit(bv[k], noise, gaps, (j * 8 + 7 - k) == zero_bit);
    end
  endtask

  task automatic check_stream(input string tag, input int n);
    chk({tag, "_count"}, rx_q.size(), n);
    for (int k = 0; k < n && k < rx_q.size() && k < exp_q.size(); k++)
      chk($sformatf("%s_byte%0d", tag, k), rx_q[k], exp_q[k]);
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, bus.o_valid_output, 1'b0);
    chk({tag, "_sync"}, bus.o_sync, 1'b0);
    chk({tag, "_done"}, bus.o_pack_done, 1'b0);
    chk({tag, "_ovf"}, bus.o_overflow, 1'b0);
    chk({tag, "_data"}, bus.o_data, 8'h00);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.i_valid_input = 1'b0;
    #1 check_idle_outputs("reset_async");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_sr = '0; m_sync = 1'b0; m_cnt = 0;
    rx_q.delete(); exp_q.delete();
  endtask

  initial begin
    bus.i_data = '0; bus.i_valid_input = 1'b0; bus.i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("por");
    rst = 1'b0;

    // Clean packet, first byte latency, sync duration
    sync_cycles = 0; done_cnt = 0; m_packs = 0;
    send_bits(PRE, 32);
    send_payload(0, 1'b0, 0, 0, -1);
    idle(1); chk("lat_t0", bus.o_valid_output, 1'b0);
    idle(1); chk("lat_t1", bus.o_valid_output, 1'b0);
    idle(1); chk("lat_t2", bus.o_valid_output, 1'b1);
    send_payload(0, 1'b0, 1, PAY_BYTES - 1, -1);
    idle(10);
    chk("clean_sync_cycles", sync_cycles, PAY_BITS * CPB + 3);
    chk("clean_done", done_cnt, m_packs);
    chk("clean_ovf", bus.o_overflow, 1'b0);
    chk("clean_first_byte", rx_q.size() > 0 ? rx_q[0] : 8'hFF, 8'h00);
    check_stream("clean", exp_q.size());

    // Hunt through a 17-bit prefix
    send_bits(32'h0001_5A5A, 17);
    send_bits(PRE, 32);
    idle(3);
    chk("hunt_no_early_bytes", rx_q.size(), 0);
    chk("hunt_sync", bus.o_sync, 1'b1);
    send_payload(0, 1'b0, 0, PAY_BYTES - 1, -1);
    idle(10);
    check_stream("hunt", exp_q.size());

    // Noise with random input gaps
    send_bits(PRE, 32);
    send_payload(600, 1'b1, 0, PAY_BYTES - 1, -1);
    idle(10);
    check_stream("noise", exp_q.size());

    // All-zero chips on byte 3 MSB decide as 1
    send_bits(PRE, 32);
    send_payload(0, 1'b0, 0, PAY_BYTES - 1, 24);
    idle(10);
    chk("zero_bit_byte", rx_q.size() > 3 ? rx_q[3] : 8'h00, 8'h83);
    check_stream("zero", exp_q.size());
    chk("done_total", done_cnt, m_packs);

    // Backpressure: hold four bytes, overflow on the fifth
    bus.i_ready = 1'b0;
    send_bits(PRE, 32);
    send_payload(0, 1'b0, 0, 3, -1);
    idle(4);
    chk("bp_ovf_after4", bus.o_overflow, 1'b0);
    chk("bp_valid", bus.o_valid_output, 1'b1);
    send_payload(0, 1'b0, 4, 4, -1);
    idle(4);
    chk("bp_ovf_after5", bus.o_overflow, 1'b1);
    send_payload(0, 1'b0, 5, PAY_BYTES - 1, -1);
    idle(4);
    chk("bp_head", bus.o_data, 8'h00);
    bus.i_ready = 1'b1;
    idle(8);
    chk("bp_ovf_sticky", bus.o_overflow, 1'b1);
    check_stream("bp", 4);
    do_reset();

    // Full FIFO push coinciding with a pop is accepted
    bus.i_ready = 1'b0;
    send_bits(PRE, 32);
    send_payload(0, 1'b0, 0, 4, -1);
    idle(1);
    @(posedge clk); #1 bus.i_ready = 1'b1;
    @(posedge clk); #1 bus.i_ready = 1'b0;
    chk("pop_push_ovf", bus.o_overflow, 1'b0);
    bus.i_ready = 1'b1;
    send_payload(0, 1'b0, 5, PAY_BYTES - 1, -1);
    idle(10);
    chk("pop_push_ovf_end", bus.o_overflow, 1'b0);
    check_stream("pop_push", exp_q.size());

    // Reset mid-payload with a byte waiting in the FIFO
    send_bits(PRE, 32);
    send_payload(0, 1'b0, 0, 2, -1);
    idle(5);
    bus.i_ready = 1'b0;
    send_payload(0, 1'b0, 3, 3, -1);
    send_bits(32'h5, 3);
    idle(3);
    chk("pre_reset_valid", bus.o_valid_output, 1'b1);
    check_stream("pre_reset", 3);
    do_reset();
    bus.i_ready = 1'b1;
    done_cnt = 0; m_packs = 0;
    send_bits(PRE, 32);
    send_payload(0, 1'b0, 0, PAY_BYTES - 1, -1);
    idle(10);
    check_stream("post_reset", exp_q.size());
    chk("post_reset_done", done_cnt, m_packs);

    // Preamble with two flipped bits
    send_bits(PRE ^ 32'h0100_0010, 32);
    send_payload(0, 1'b0, 0, PAY_BYTES - 1, -1);
    idle(10);
    chk("tol2_bytes_expected", exp_q.size(), (TOL >= 2) ? PAY_BYTES : 0);
    check_stream("tol2", exp_q.size());

    // Preamble with three flipped bits
    send_bits(PRE ^ 32'h8000_0101, 32);
    send_payload(0, 1'b0, 0, PAY_BYTES - 1, -1);
    idle(10);
    check_stream("tol3", exp_q.size());
    chk("tol_done", done_cnt, m_packs);

    // Back-to-back packets
    send_bits(PRE, 32);
    send_payload(0, 1'b0, 0, PAY_BYTES - 1, -1);
    send_bits(PRE, 32);
    send_payload(0, 1'b0, 0, PAY_BYTES - 1, -1);
    idle(10);
    check_stream("b2b", exp_q.size());
    chk("b2b_done", done_cnt, m_packs);
    chk("final_ovf", bus.o_overflow, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/packet_demodulator.md
Name: packet_demodulator

Overview:
- Receive-side counterpart of the packet Modulator.
- Accepts a stream of 32-bit IQ samples: Q in [31:16], I in [15:0], both signed 16-bit.
- Despreads each bit over CHIPS_PER_BIT chips of a fixed ±1 code and hunts for the 32-bit preamble. After a preamble match, it recovers the payload bits and delivers them as bytes, MSB first.
- Output bytes pass through a 4-entry byte FIFO that accepts downstream backpressure.

Parameters:
- SIZE_OUTPUT_BIT, 8, output byte width.
- SIZE_INPUT_BIT, 32, IQ sample width.
- SIZE_QI, 16, width of each of I and Q.
- SIZE_BIT_PACK, 1976, total packet bits including preamble.
- SISE_PREAMBLE, 32, preamble length in bits.
- PREAMBLE, 32'hEB90_EB90, preamble pattern; first transmitted bit is the MSB.
- CHIPS_PER_BIT, 30, samples per bit.
- CODE, 30'h1E5C_9E21, spreading code; chip c uses CODE[CHIPS_PER_BIT-1-c]; 1 means +1, 0 means -1.
- MAX_ERR, 2, preamble bit-error tolerance; used only with the optional feature.
- FIFO_DEPTH, 4, output FIFO entries (power of two).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset, asynchronous, active-high.
- i_data  in  32  IQ sample.
- i_valid_input  in  1  sample valid; gaps are allowed.
- o_data  out  8  recovered byte (FIFO head).
- o_valid_output  out  1  FIFO not empty.
- i_ready  in  1  downstream accepts o_data.
- o_sync  out  1  high while in PAYLOAD.
- o_pack_done  out  1  one-cycle pulse when the last payload byte is written into the FIFO.
- o_overflow  out  1  sticky; a byte was dropped because the FIFO was full.

Behaviour:
- Reset: asynchronous, clears everything.
  - All outputs 0; state HUNT.
  - Accumulator, chip counter, preamble shift register, bit counter and FIFO pointers all 0.
  - A reset mid-packet discards the partial packet and all FIFO contents.
- Despread:
  - On each valid sample: acc += (code chip ? +I : -I).
  - Accumulator width is SIZE_QI + $clog2(CHIPS_PER_BIT) + 1 (22 bits by default), signed, and never saturates.
  - chip_cnt counts 0..CHIPS_PER_BIT-1 and wraps. Q is ignored.
  - When chip_cnt == CHIPS_PER_BIT-1 on a valid sample: the bit is the sign of (acc + contribution), with value ≥ 0 giving 1.
  - In that cycle, acc and chip_cnt reload to 0. The bit is registered and bit_valid pulses on the next cycle.
  - chip_cnt is free-running from reset; the input stream must start chip-aligned after reset.
- FSM, two states:
  - HUNT: on each bit_valid, sr <= {sr[30:0], bit}. If the shifted value equals PREAMBLE, go to PAYLOAD on the next cycle, o_sync=1, bit counter 0.
  - PAYLOAD: on each bit_valid, the bit enters a byte shift register MSB first; the bit counter increments.
  - Every 8th bit, the assembled byte is pushed into the FIFO in the following cycle.
  - There are SIZE_BIT_PACK-SISE_PREAMBLE = 1944 payload bits (243 bytes).
  - After the 1944th bit: push the final byte, pulse o_pack_done in the same cycle as that push, o_sync=0, sr cleared to 0, return to HUNT.
  - Back-to-back packets: the next preamble may start on the very next bit period.
- FIFO:
  - Show-ahead: o_data = head, o_valid_output = !empty.
  - Pop when o_valid_output && i_ready.
  - Push when full without a same-cycle pop: the byte is dropped and o_overflow is set until reset. The FSM continues regardless.
  - Push while full with a same-cycle pop: the push is accepted.
  - Push while empty: o_valid_output goes high the next cycle.
- Latency: final chip sample → o_valid_output of the completed byte is 3 cycles when the FIFO was empty (bit reg, byte push, FIFO output).

Optional Feature:
- DEMOD_PREAMBLE_TOL_EN defined: a preamble match is declared when the Hamming distance between the shifted sr value and PREAMBLE is ≤ MAX_ERR. The popcount is combinational.
- Not defined: the match requires exact equality, and MAX_ERR is unused.

Test Plan:
- Clean packet: I = ±1000 per chip (Q=0), PREAMBLE, then payload bytes 0x00..0xF2 → 243 bytes 0x00..0xF2 out in order; one o_pack_done; o_overflow=0; o_sync high for exactly 1944 bit periods.
- Hunt: 17 bits of pattern 0x1_5A5A before the preamble → no output bytes before sync; same 243 bytes recovered afterwards.
- Noise/sign:
  - Add ±600 random noise per chip → all bytes correct.
  - A bit whose chips all equal 0 → decided as 1.
- Backpressure: i_ready=0 for the whole packet → first 4 bytes 0x00..0x03 held; o_overflow=1 after the 5th byte.
  - With i_ready=1 and a simultaneous pop, a push to a full FIFO is not flagged.
- Reset mid-payload at byte 100 → all outputs 0 within the reset cycle; the next clean packet decodes fully.
- Tolerance: preamble with 2 bits flipped → decodes with DEMOD_PREAMBLE_TOL_EN, no sync without it; 3 bits flipped → no sync in either build.
